// File: rtl/rr_mux8_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux8_arbiter
//
// Round-robin arbiter that shares one 8:1 single-bit mux between 8
// requesters. Requester i owns data_in[i]. While a requester holds the grant,
// the arbiter drives the mux select so that out_y carries that requester's bit.
//
// Each grant lasts at most MAX_HOLD cycles. After every grant there is one
// mandatory idle cycle. The search for the next owner starts one past the
// previous owner, so priority rotates.
//
// Parameters:
//   MAX_HOLD   maximum consecutive cycles a grant may be held (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req[7:0]   request vector, req[i]=1 -> requester i wants the mux
//   data_in    mux data inputs, data_in[i] belongs to requester i
//   sel[2:0]   registered mux select (current or last granted index)
//   gnt[7:0]   registered one-hot grant, zero when nothing is granted
//   gnt_valid  registered, 1 while in GRANT (equals |gnt)
//   out_y      combinational mux output, data_in[sel] when gnt_valid else 0
//   state_dbg  debug view of the FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: req[i] is a level request. The arbiter samples req in IDLE and
// asserts gnt one edge later; the owner keeps req[i] high for as long as it
// wants the mux. Dropping req[i] releases the grant at the next edge. Grants
// are never preempted by other round-robin requesters.
//
// Optional feature (macro RR_ARB_PRIO0_EN):
//   When defined, requester 0 is high priority: it wins every IDLE
//   arbitration, and req[0] forces release of any grant held by another
//   requester at the next edge. Requester 0 is still bounded by MAX_HOLD.
// -----------------------------------------------------------------------------
module rr_mux8_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       out_y,
  output logic       state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e     state_q;
  logic [2:0] sel_q;
  logic [7:0] gnt_q;
  logic       gnt_valid_q;
  logic [2:0] ptr_q;
  logic [3:0] hold_q;

  // Winner of an IDLE arbitration: first requester at or after ptr_q,
  // wrapping 7 -> 0.
  logic [2:0] pick_d;
  logic       any_req;

  always_comb begin
    pick_d  = ptr_q;
    any_req = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      // Scanning downward lets the lowest offset overwrite last, so the
      // closest requester to ptr_q wins.
      if (req[ptr_q + 3'(k)]) begin
        pick_d  = ptr_q + 3'(k);
        any_req = 1'b1;
      end
    end
`ifdef RR_ARB_PRIO0_EN
    if (req[0]) begin
      pick_d  = 3'd0;
      any_req = 1'b1;
    end
`endif
  end

  // Release condition evaluated while in GRANT.
  logic release_d;

  always_comb begin
    release_d = !req[sel_q] || (hold_q == HOLD_LAST);
`ifdef RR_ARB_PRIO0_EN
    if (sel_q != 3'd0 && req[0]) begin
      release_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 3'd0;
      hold_q      <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            sel_q       <= pick_d;
            gnt_q       <= 8'h01 << pick_d;
            gnt_valid_q <= 1'b1;
            hold_q      <= 4'd0;
            state_q     <= S_GRANT;
          end else begin
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
          end
        end
        S_GRANT: begin
          if (release_d) begin
            // sel keeps the last owner; the next search starts just past it.
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            ptr_q       <= sel_q + 3'd1;
            state_q     <= S_IDLE;
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          gnt_q       <= 8'h00;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign out_y     = gnt_valid_q ? data_in[sel_q] : 1'b0;
  assign state_dbg = (state_q == S_GRANT);

endmodule
